// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and transfer-direction constants for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable wait-state down-counter that holds at zero
module wait_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);
  logic [CNT_W-1:0] count;
  assign done = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (en && !done) count <= count - 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency memory port between two requesters
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_strobe,
  input  logic          req0_rw,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_rdy,
  input  logic          req1_strobe,
  input  logic          req1_rw,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_rdy,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic          mem_strobe,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  import mem_arb_pkg::*;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MEM_LAT - 1);
  arb_state_t state;
  logic last, pick1, grant, cnt_done;
  // last=1 means requester 1 was served most recently, so requester 0 wins a tie
  assign pick1      = req1_strobe && (!req0_strobe || !last);
  assign grant      = state == IDLE && (req0_strobe || req1_strobe);
  assign mem_strobe = state == ACCESS;
  assign req0_rdy   = state == DONE && gnt[0];
  assign req1_rdy   = state == DONE && gnt[1];
  wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant),
    .load_val (LOAD),
    .en       (mem_strobe),
    .done     (cnt_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= 1'b1;
      mem_rw    <= RD;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else if (grant) begin
      state     <= ACCESS;
      gnt       <= pick1 ? 2'b10 : 2'b01;
      last      <= pick1;
      mem_rw    <= pick1 ? req1_rw : req0_rw;
      mem_addr  <= pick1 ? req1_addr : req0_addr;
      mem_wdata <= pick1 ? req1_wdata : req0_wdata;
    end else if (state == ACCESS && cnt_done) begin
      state <= DONE;
      if (mem_rw == RD) rdata <= mem_rdata;
    end else if (state == DONE) begin
      state <= IDLE;
      gnt   <= '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter at MEM_LAT=4 and MEM_LAT=1
module tb_mem_arbiter;
  localparam int S_GNT = 0, S_STB = 1, S_ADDR = 2, S_RW = 3, S_WD = 4, S_RD = 5, S_STB1 = 6;
  typedef struct {int cyc; int sig; logic [31:0] val;} tchk_t;
  typedef struct {int id; int cyc; logic [31:0] rdata;} rdy_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic r0_s = 0, r0_rw = 0, r0_rdy, r1_s = 0, r1_rw = 0, r1_rdy;
  logic [15:0] r0_a = '0, r1_a = '0, mem_addr;
  logic [31:0] r0_wd = '0, r1_wd = '0, rdata, mem_wdata, mem_rdata;
  logic [1:0] gnt;
  logic mem_strobe, mem_rw;
  logic b_s = 0, b_rdy, b_unused_rdy, b_strobe, b_rw;
  logic [15:0] b_a = '0, b_mem_addr;
  logic [31:0] b_rdata, b_mem_wdata, b_mem_rdata;
  logic [1:0] b_gnt;
  int cyc = 0, scnt = 0, checks = 0, errors = 0;
  bit done = 0;
  tchk_t tq[$];
  rdy_t q0[$], q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) scnt <= mem_strobe ? scnt + 1 : 0;
  function automatic logic [31:0] f(input logic [15:0] a);
    return a == 16'h0040 ? 32'hDEADBEEF : {~a, a};
  endfunction
  assign mem_rdata   = (mem_strobe && scnt == 3) ? f(mem_addr) : 32'hBAD0BAD0;
  assign b_mem_rdata = b_strobe ? f(b_mem_addr) : 32'hBAD0BAD0;
  mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_strobe(r0_s), .req0_rw(r0_rw), .req0_addr(r0_a), .req0_wdata(r0_wd), .req0_rdy(r0_rdy),
    .req1_strobe(r1_s), .req1_rw(r1_rw), .req1_addr(r1_a), .req1_wdata(r1_wd), .req1_rdy(r1_rdy),
    .rdata(rdata), .gnt(gnt), .mem_strobe(mem_strobe), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_strobe(b_s), .req0_rw(1'b0), .req0_addr(b_a), .req0_wdata(32'h0), .req0_rdy(b_rdy),
    .req1_strobe(1'b0), .req1_rw(1'b0), .req1_addr(16'h0), .req1_wdata(32'h0), .req1_rdy(b_unused_rdy),
    .rdata(b_rdata), .gnt(b_gnt), .mem_strobe(b_strobe), .mem_rw(b_rw), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );
  function automatic logic [31:0] get(input int s);
    case (s)
      S_GNT:   return {30'b0, gnt};
      S_STB:   return {31'b0, mem_strobe};
      S_ADDR:  return {16'b0, mem_addr};
      S_RW:    return {31'b0, mem_rw};
      S_WD:    return mem_wdata;
      S_RD:    return rdata;
      default: return {31'b0, b_strobe};
    endcase
  endfunction
  function automatic string nm(input int s);
    case (s)
      S_GNT:   return "gnt";
      S_STB:   return "mem_strobe";
      S_ADDR:  return "mem_addr";
      S_RW:    return "mem_rw";
      S_WD:    return "mem_wdata";
      S_RD:    return "rdata";
      default: return "lat1_mem_strobe";
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", n, cyc, act, exp);
    end
  endtask
  task automatic at(input int c, input int s, input logic [31:0] v);
    tq.push_back('{c, s, v});
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    rdy_t e;
    if (done) begin
      chk("pending_expectations", tq.size() + q0.size() + q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    for (int i = tq.size() - 1; i >= 0; i--)
      if (tq[i].cyc <= cyc) begin
        chk(nm(tq[i].sig), tq[i].cyc < cyc ? 32'hFFFFFFFF : get(tq[i].sig), tq[i].val);
        tq.delete(i);
      end
    if (r0_rdy || r1_rdy) begin
      if (q0.size() == 0) chk("spurious_rdy", {30'b0, r1_rdy, r0_rdy}, 0);
      else begin
        e = q0.pop_front();
        chk("rdy_owner", {30'b0, r1_rdy, r0_rdy}, e.id == 1 ? 2 : 1);
        chk("rdy_cycle", cyc, e.cyc);
        chk("rdy_rdata", rdata, e.rdata);
      end
    end else if (q0.size() != 0 && q0[0].cyc < cyc) begin
      e = q0.pop_front();
      chk("missing_rdy", {30'b0, r1_rdy, r0_rdy}, e.id == 1 ? 2 : 1);
    end
    if (b_rdy) begin
      if (q1.size() == 0) chk("lat1_spurious_rdy", {31'b0, b_rdy}, 0);
      else begin
        e = q1.pop_front();
        chk("lat1_rdy_cycle", cyc, e.cyc);
        chk("lat1_rdata", b_rdata, e.rdata);
      end
    end else if (q1.size() != 0 && q1[0].cyc < cyc) begin
      e = q1.pop_front();
      chk("lat1_missing_rdy", {31'b0, b_rdy}, 1);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end
  initial begin
    int t;
    tick(1);
    t = cyc;
    at(t + 1, S_GNT, 0); at(t + 1, S_STB, 0); at(t + 1, S_ADDR, 0); at(t + 1, S_RD, 0); at(t + 1, S_STB1, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    t = cyc;
    b_s = 1; b_a = 16'h0077;
    q1.push_back('{0, t + 2, f(16'h0077)});
    at(t + 1, S_STB1, 1); at(t + 2, S_STB1, 0); at(t + 3, S_STB1, 0);
    tick(2);
    b_s = 0;
    tick(2);
    t = cyc;
    r0_s = 1; r0_rw = 0; r0_a = 16'h0010;
    r1_s = 1; r1_rw = 0; r1_a = 16'h0020;
    q0.push_back('{0, t + 5, f(16'h0010)});
    q0.push_back('{1, t + 11, f(16'h0020)});
    q0.push_back('{0, t + 17, f(16'h0010)});
    q0.push_back('{1, t + 23, f(16'h0020)});
    at(t + 1, S_GNT, 1); at(t + 6, S_GNT, 0); at(t + 7, S_GNT, 2); at(t + 13, S_GNT, 1); at(t + 19, S_GNT, 2);
    at(t + 1, S_ADDR, 16'h0010); at(t + 7, S_ADDR, 16'h0020);
    at(t + 4, S_STB, 1); at(t + 5, S_STB, 0); at(t + 6, S_STB, 0); at(t + 7, S_STB, 1);
    tick(17);
    r0_s = 0;
    tick(6);
    r1_s = 0;
    tick(2);
    t = cyc;
    r0_s = 1; r0_rw = 0; r0_a = 16'h0040;
    q0.push_back('{0, t + 5, 32'hDEADBEEF});
    for (int k = 1; k <= 4; k++) at(t + k, S_STB, 1);
    at(t + 5, S_STB, 0); at(t + 1, S_ADDR, 16'h0040); at(t + 2, S_RW, 0);
    at(t + 1, S_GNT, 1); at(t + 5, S_GNT, 1); at(t + 6, S_GNT, 0);
    tick(5);
    r0_s = 0;
    tick(2);
    t = cyc;
    r1_s = 1; r1_rw = 1; r1_a = 16'h0100; r1_wd = 32'h12345678;
    q0.push_back('{1, t + 5, 32'hDEADBEEF});
    for (int k = 1; k <= 4; k++) at(t + k, S_RW, 1);
    at(t + 1, S_WD, 32'h12345678); at(t + 4, S_STB, 1); at(t + 5, S_STB, 0);
    at(t + 2, S_GNT, 2); at(t + 3, S_ADDR, 16'h0100); at(t + 6, S_RD, 32'hDEADBEEF);
    tick(5);
    r1_s = 0;
    tick(2);
    t = cyc;
    r0_s = 1; r0_rw = 0; r0_a = 16'h0200;
    r1_s = 1; r1_rw = 0; r1_a = 16'h0300;
    q0.push_back('{0, t + 5, f(16'h0200)});
    q0.push_back('{1, t + 11, f(16'h0300)});
    at(t + 1, S_GNT, 1); at(t + 7, S_GNT, 2); at(t + 7, S_ADDR, 16'h0300);
    tick(2);
    r0_s = 0;
    tick(9);
    r1_s = 0;
    tick(2);
    r0_s = 1; r0_rw = 0; r0_a = 16'h0400;
    tick(2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    r0_s = 0;
    t = cyc;
    at(t, S_GNT, 0); at(t, S_STB, 0); at(t, S_ADDR, 0); at(t, S_RD, 0); at(t, S_WD, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    t = cyc;
    r1_s = 1; r1_rw = 0; r1_a = 16'h0500;
    q0.push_back('{1, t + 5, f(16'h0500)});
    at(t + 1, S_GNT, 2); at(t + 1, S_STB, 1); at(t + 4, S_STB, 1); at(t + 5, S_STB, 0);
    tick(5);
    r1_s = 0;
    tick(3);
    done = 1;
  end
endmodule
